// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and a sync-level helper for the
// VGA sync generator and its counters.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 0 = active-low sync pulses (standard for 640x480@60)
    localparam bit VGA_SYNC_ACT = 1'b0;
    localparam int VGA_CNT_W    = 10;

    function automatic logic sync_level(input logic in_pulse, input bit act);
        return in_pulse ? act : ~act;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Enable-gated raster axis counter that wraps MAX -> 0; resets to MAX so the
// first enabled cycle lands on 0.
module vga_axis_counter #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         terminal
);

    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign terminal  = (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: h/v counters advanced by the pixel tick, with sync,
// video-on and line/frame strobes registered from the next-count values.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_ACT = VGA_SYNC_ACT,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_tick,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_line_start,
    output logic             o_frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    if (H_TOTAL > (1 << CNT_W)) begin : g_h_width_chk
        $error("vga_sync_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_v_width_chk
        $error("vga_sync_gen: V_TOTAL does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] h_cnt, h_nxt;
    logic [CNT_W-1:0] v_cnt, v_nxt;
    logic             h_terminal;
    logic             v_terminal;

    vga_axis_counter #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_h_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .en        (i_pix_tick),
        .count     (h_cnt),
        .count_nxt (h_nxt),
        .terminal  (h_terminal)
    );

    vga_axis_counter #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_v_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .en        (i_pix_tick && h_terminal),
        .count     (v_cnt),
        .count_nxt (v_nxt),
        .terminal  (v_terminal)
    );

    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic video_on_d, video_on_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    // Decoding from the next-count values keeps every output aligned with o_x/o_y.
    always_comb begin
        hsync_d       = sync_level((32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END), SYNC_ACT);
        vsync_d       = sync_level((32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END), SYNC_ACT);
        video_on_d    = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
        line_start_d  = i_pix_tick && (h_nxt == '0);
        frame_start_d = i_pix_tick && (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_video_on    = video_on_q;
    assign o_x           = h_cnt;
    assign o_y           = v_cnt;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing plus a tiny-raster
// instance with active-high syncs checked every cycle.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Default 640x480 instance
    logic       rst_n, tick;
    logic       hs, vs, vid, ls, fs;
    logic [9:0] x, y;

    vga_sync_gen dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_tick    (tick),
        .o_hsync       (hs),
        .o_vsync       (vs),
        .o_video_on    (vid),
        .o_x           (x),
        .o_y           (y),
        .o_line_start  (ls),
        .o_frame_start (fs)
    );

    // Small-raster instance: 8 x 6 total, active-high syncs
    logic       rst_n_s, tick_s;
    logic       hs_s, vs_s, vid_s, ls_s, fs_s;
    logic [3:0] x_s, y_s;

    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACT(1'b1), .CNT_W(4)
    ) dut_s (
        .i_clk         (clk),
        .i_rst_n       (rst_n_s),
        .i_pix_tick    (tick_s),
        .o_hsync       (hs_s),
        .o_vsync       (vs_s),
        .o_video_on    (vid_s),
        .o_x           (x_s),
        .o_y           (y_s),
        .o_line_start  (ls_s),
        .o_frame_start (fs_s)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; rst_n_s = 1'b0; tick_s = 1'b0;
        step(); step();
        total++;
        if ({x, y, vid, hs, vs, ls, fs} !== {10'd799, 10'd524, 5'b01100})
            $display("FAIL reset_state: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 799/524/0/1/1/0/0",
                     x, y, vid, hs, vs, ls, fs);
        else passed++;

        rst_n = 1'b1;
        step(); step(); step();
        total++;
        if ({x, y, vid, hs, vs, ls, fs} !== {10'd799, 10'd524, 5'b01100})
            $display("FAIL pre_first_tick: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 799/524/0/1/1/0/0",
                     x, y, vid, hs, vs, ls, fs);
        else passed++;

        tick = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if ({x, y, vid, hs, vs, ls, fs} !== {10'd0, 10'd0, 5'b11111})
            $display("FAIL first_tick: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 0/0/1/1/1/1/1",
                     x, y, vid, hs, vs, ls, fs);
        else passed++;

        step();
        total++;
        if ({x, ls, fs} !== {10'd0, 2'b00})
            $display("FAIL strobe_one_clock: got x=%0d ls=%b fs=%b, exp x=0 ls=0 fs=0", x, ls, fs);
        else passed++;
    endtask

    // Two full lines with a tick every 4th clock, starting from (0,0).
    task automatic test_line_timing();
        int   hs_low   = 0;
        int   hs_first = -1;
        int   hs_last  = -1;
        int   vid_fall = -1;
        int   fs_cnt   = 0;
        int   period;
        int   ls_idx[$];
        logic prev_vid;

        prev_vid = vid;
        for (int i = 0; i < 6400; i++) begin
            tick = (i % 4 == 0);
            step();
            if (hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(x);
                hs_last = int'(x);
            end
            if (prev_vid && !vid && vid_fall < 0) vid_fall = int'(x);
            prev_vid = vid;
            if (ls) ls_idx.push_back(i);
            if (fs) fs_cnt++;
        end
        tick = 1'b0;

        total++;
        if (hs_low !== 768) $display("FAIL hsync_low_clocks: got %0d exp 768", hs_low);
        else passed++;
        total++;
        if (hs_first !== 656) $display("FAIL hsync_first_x: got %0d exp 656", hs_first);
        else passed++;
        total++;
        if (hs_last !== 751) $display("FAIL hsync_last_x: got %0d exp 751", hs_last);
        else passed++;
        total++;
        if (vid_fall !== 640) $display("FAIL video_fall_x: got %0d exp 640", vid_fall);
        else passed++;
        total++;
        if (ls_idx.size() !== 2) $display("FAIL line_start_count: got %0d exp 2", ls_idx.size());
        else passed++;
        period = (ls_idx.size() >= 2) ? ls_idx[1] - ls_idx[0] : -1;
        total++;
        if (period !== 3200) $display("FAIL line_start_period: got %0d exp 3200", period);
        else passed++;
        total++;
        if (fs_cnt !== 0) $display("FAIL no_frame_start_mid_frame: got %0d exp 0", fs_cnt);
        else passed++;
        total++;
        if ({x, y} !== {10'd0, 10'd2}) $display("FAIL after_two_lines: got x=%0d y=%0d exp 0/2", x, y);
        else passed++;
    endtask

    // From (0,2), 43 lines + 123 pixels reaches (123,45); then hold tick low.
    task automatic test_pause();
        int dev = 0;

        tick = 1'b1;
        repeat (34523) step();
        tick = 1'b0;
        total++;
        if ({x, y, hs, vs, vid} !== {10'd123, 10'd45, 3'b111})
            $display("FAIL reach_123_45: got x=%0d y=%0d hs=%b vs=%b vid=%b exp 123/45/1/1/1", x, y, hs, vs, vid);
        else passed++;

        for (int i = 0; i < 1000; i++) begin
            step();
            if ({x, y, hs, vs, vid, ls, fs} !== {10'd123, 10'd45, 5'b11100}) dev++;
        end
        total++;
        if (dev !== 0) $display("FAIL pause_hold: got %0d changed cycles exp 0", dev);
        else passed++;
    endtask

    task automatic test_reset_mid();
        tick = 1'b1;
        repeat (177) step();
        tick = 1'b0;
        total++;
        if ({x, y, vid} !== {10'd300, 10'd45, 1'b1})
            $display("FAIL reach_300_45: got x=%0d y=%0d vid=%b exp 300/45/1", x, y, vid);
        else passed++;

        tick = 1'b1; rst_n = 1'b0;
        step();
        total++;
        if ({x, y, vid, hs, vs, ls, fs} !== {10'd799, 10'd524, 5'b01100})
            $display("FAIL mid_reset: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 799/524/0/1/1/0/0",
                     x, y, vid, hs, vs, ls, fs);
        else passed++;

        step();
        tick = 1'b0; rst_n = 1'b1;
        step();
        total++;
        if ({x, y, vid, hs, vs, ls, fs} !== {10'd799, 10'd524, 5'b01100})
            $display("FAIL no_tick_counted_in_reset: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 799/524/0/1/1/0/0",
                     x, y, vid, hs, vs, ls, fs);
        else passed++;

        tick = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if ({x, y, vid, hs, vs, ls, fs} !== {10'd0, 10'd0, 5'b11111})
            $display("FAIL restart_after_reset: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 0/0/1/1/1/1/1",
                     x, y, vid, hs, vs, ls, fs);
        else passed++;
    endtask

    // Tiny raster, tick held high: expected position derived from tick count.
    task automatic test_small_frame();
        int   vs_hi = 0;
        int   ex, ey, pos;
        int   fs_idx[$];
        int   fs_period;
        logic e_hs, e_vs, e_vid, e_ls, e_fs;

        total++;
        if ({x_s, y_s, vid_s, hs_s, vs_s, ls_s, fs_s} !== {4'd7, 4'd5, 5'b00000})
            $display("FAIL small_reset: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp 7/5/0/0/0/0/0",
                     x_s, y_s, vid_s, hs_s, vs_s, ls_s, fs_s);
        else passed++;

        rst_n_s = 1'b1; tick_s = 1'b1;
        for (int n = 0; n < 144; n++) begin
            step();
            pos   = n % 48;
            ex    = pos % 8;
            ey    = pos / 8;
            e_hs  = (ex == 5) || (ex == 6);
            e_vs  = (ey == 4);
            e_vid = (ex < 4) && (ey < 3);
            e_ls  = (ex == 0);
            e_fs  = (ex == 0) && (ey == 0);
            total++;
            if ({x_s, y_s, vid_s, hs_s, vs_s, ls_s, fs_s} !== {4'(ex), 4'(ey), e_vid, e_hs, e_vs, e_ls, e_fs})
                $display("FAIL small_cycle_%0d: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, exp %0d/%0d/%b/%b/%b/%b/%b",
                         n, x_s, y_s, vid_s, hs_s, vs_s, ls_s, fs_s, ex, ey, e_vid, e_hs, e_vs, e_ls, e_fs);
            else passed++;
            if (vs_s) vs_hi++;
            if (fs_s) fs_idx.push_back(n);
        end
        tick_s = 1'b0;

        total++;
        if (vs_hi !== 24) $display("FAIL small_vsync_clocks: got %0d exp 24", vs_hi);
        else passed++;
        fs_period = (fs_idx.size() >= 2) ? fs_idx[1] - fs_idx[0] : -1;
        total++;
        if ({fs_idx.size(), fs_period} !== {32'd3, 32'd48})
            $display("FAIL small_frame_start: got count=%0d period=%0d exp 3/48", fs_idx.size(), fs_period);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_pause();
        test_reset_mid();
        test_small_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
